// File: rtl/if_sequencer.sv
// Fetch-stage sequencer: PC/IF-ID/ID-EX write and flush control for load-use
// stalls, taken-branch redirects, and boot/run/halt/single-step sequencing.
module if_sequencer #(
  parameter int BOOT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             MemRead_EX,
  input  logic [4:0]       RD_EX,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic             PCSrc_EX,
  output logic             PC_write,
  output logic             PCSrc,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT,
    ST_STEP
  } state_t;

  state_t            state_reg, state_next;
  logic [BW-1:0]     boot_cnt_reg;
  logic [CNT_W-1:0]  stall_cnt_reg, flush_cnt_reg;
  logic              luh;
  logic              stall_apply;
  logic              active;

  assign luh = MemRead_EX & (RD_EX != 5'd0) &
               ((RD_EX == RS1_ID) | (RD_EX == RS2_ID));

  assign active      = (state_reg == ST_RUN) | (state_reg == ST_STEP);
  assign stall_apply = active & luh & ~PCSrc_EX;

  always_comb begin
    PC_write    = 1'b0;
    PCSrc       = 1'b0;
    IF_ID_write = 1'b0;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    state_next  = state_reg;

    case (state_reg)
      ST_BOOT: begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
        if (boot_cnt_reg == BOOT_LAST) begin
          state_next = run ? ST_RUN : ST_HALT;
        end
      end
      default: begin
        // A redirect wins everywhere outside BOOT so a draining branch is never lost.
        if (PCSrc_EX) begin
          PCSrc       = 1'b1;
          PC_write    = 1'b1;
          IF_ID_write = 1'b1;
          IF_ID_flush = 1'b1;
          ID_EX_flush = 1'b1;
        end else if (state_reg == ST_HALT || luh) begin
          ID_EX_flush = 1'b1;
        end else begin
          PC_write    = 1'b1;
          IF_ID_write = 1'b1;
        end

        case (state_reg)
          ST_RUN: begin
            if (!run) state_next = ST_HALT;
          end
          ST_HALT: begin
            if (run)       state_next = ST_RUN;
            else if (step) state_next = ST_STEP;
          end
          ST_STEP: begin
            if (run)           state_next = ST_RUN;
            else if (PC_write) state_next = ST_HALT;
          end
          default: state_next = state_reg;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_BOOT;
      boot_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_BOOT && boot_cnt_reg != BOOT_LAST) begin
        boot_cnt_reg <= boot_cnt_reg + BW'(1);
      end
      if (stall_apply && stall_cnt_reg != '1) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      if (PCSrc && flush_cnt_reg != '1) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign halted    = (state_reg == ST_HALT);
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule
